// File: rtl/data_cache_if.sv
// Backing-memory side of the data cache: line reads and word writes.
// The cache is the master; the memory model or controller is the slave.
interface data_cache_if;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    logic [63:0] mem_data_in;
    logic [15:0] mem_data_out;

    modport master (
        output mem_readM,
        output mem_writeM,
        output mem_address,
        output mem_data_out,
        input  mem_data_in
    );

    modport slave (
        input  mem_readM,
        input  mem_writeM,
        input  mem_address,
        input  mem_data_out,
        output mem_data_in
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-through no-write-allocate cache, 4 lines x 4 words x 16 bits.
// Hits are combinational; a miss takes 1+MEM_LATENCY cycles before the held request hits.
// No backpressure on the CPU: requests are held by the CPU while it stalls, ignored outside IDLE.
module data_cache #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        readM,
    input  logic        writeM,
    input  logic [15:0] address,
    inout  wire  [15:0] data,
    output logic        is_hit,
    output logic        is_miss,
    output logic [15:0] miss_count,
    data_cache_if.master mem
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
    localparam logic [1:0] LAST_CYC = 2'(MEM_LATENCY - 1);

    logic [15:0] line_dat [4][4];
    logic [11:0] line_tag [4];
    logic [3:0]  line_vld;

    state_t      state;
    logic [1:0]  cyc;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdat_q;
    logic        done;
    logic [15:0] done_addr;
    logic [15:0] done_dat;

    logic [1:0]  req_idx;
    logic [1:0]  acc_idx;
    logic        idle;
    logic        read_hit;
    logic        done_match;
    logic        last_cyc;
    logic        fill;
    logic        wr_done;
    logic        wr_hit;

    assign req_idx    = address[3:2];
    assign acc_idx    = mem_addr_q[3:2];
    assign idle       = (state == IDLE);
    assign read_hit   = readM && line_vld[req_idx] && (line_tag[req_idx] == address[15:4]);
    assign done_match = done && writeM && (address == done_addr) && (data == done_dat);
    assign is_hit     = idle && (read_hit || done_match);
    assign is_miss    = idle && ((readM && !read_hit) || (writeM && !done_match));
    assign last_cyc   = (cyc == LAST_CYC);
    assign fill       = (state == FETCH) && last_cyc;
    assign wr_done    = (state == WRITE) && last_cyc;
    assign wr_hit     = line_vld[acc_idx] && (line_tag[acc_idx] == mem_addr_q[15:4]);

    assign data = (idle && read_hit) ? line_dat[req_idx][address[1:0]] : 'z;

    assign mem.mem_readM    = mem_rd_q;
    assign mem.mem_writeM   = mem_wr_q;
    assign mem.mem_address  = mem_addr_q;
    assign mem.mem_data_out = mem_wdat_q;

    // Payload storage needs no reset: reset forces IDLE, so fill/wr_done cannot fire during it.
    always_ff @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 4; k++) begin
                line_dat[acc_idx][k] <= mem.mem_data_in[16*k +: 16];
            end
            line_tag[acc_idx] <= mem_addr_q[15:4];
        end else if (wr_done && wr_hit) begin
            line_dat[acc_idx][mem_addr_q[1:0]] <= mem_wdat_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cyc        <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            done       <= 1'b0;
            done_addr  <= '0;
            done_dat   <= '0;
            line_vld   <= '0;
            miss_count <= '0;
        end else begin
            if (is_miss) begin
                miss_count <= miss_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    cyc <= '0;
                    if (!done_match) begin
                        done <= 1'b0;
                    end
                    if (readM && !read_hit) begin
                        state      <= FETCH;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {address[15:2], 2'b00};
                    end else if (writeM && !done_match) begin
                        state      <= WRITE;
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= address;
                        mem_wdat_q <= data;
                    end
                end
                FETCH: begin
                    if (last_cyc) begin
                        state             <= IDLE;
                        mem_rd_q          <= 1'b0;
                        line_vld[acc_idx] <= 1'b1;
                    end else begin
                        cyc <= cyc + 2'd1;
                    end
                end
                WRITE: begin
                    // The done-flag lets the still-held identical store read as a hit.
                    if (last_cyc) begin
                        state     <= IDLE;
                        mem_wr_q  <= 1'b0;
                        done      <= 1'b1;
                        done_addr <= mem_addr_q;
                        done_dat  <= mem_wdat_q;
                    end else begin
                        cyc <= cyc + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
